// File: rtl/pe_traffic_gen.sv
// rtl/pe_traffic_gen.sv - PE-side packet injector and NIC input drainer
module pe_traffic_gen #(
   parameter int PACKET_WIDTH = 64,
   parameter int NUM_PKTS     = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [31:0]             hdr,
   input  logic [7:0]              gap,
   output logic [1:0]              addr,
   output logic [PACKET_WIDTH-1:0] d_in,
   input  logic [PACKET_WIDTH-1:0] d_out,
   output logic                    nicEn,
   output logic                    nicEnWR,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             tx_count,
   output logic [15:0]             rx_count,
   output logic [PACKET_WIDTH-1:0] rx_last
);

   localparam logic [15:0] NUM_PKTS_W = 16'(NUM_PKTS);

   localparam logic [1:0] A_IN_DATA  = 2'b00;
   localparam logic [1:0] A_IN_STAT  = 2'b01;
   localparam logic [1:0] A_OUT_DATA = 2'b10;
   localparam logic [1:0] A_OUT_STAT = 2'b11;

   typedef enum logic [2:0] {
      IDLE, TXQ, TXS, TXW, RXQ, RXS, RXR, RXD
   } state_t;

   state_t                  state_q, state_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [15:0]             tx_q, tx_d;
   logic [15:0]             rx_cnt_q, rx_cnt_d;
   logic [PACKET_WIDTH-1:0] rx_last_q, rx_last_d;
   logic [7:0]              gap_cnt_q, gap_cnt_d;
   logic [7:0]              gap_r_q, gap_r_d;
   logic [31:0]             hdr_r_q, hdr_r_d;
   logic [1:0]              addr_q, addr_d;
   logic [PACKET_WIDTH-1:0] d_in_q, d_in_d;
   logic                    en_q, en_d;
   logic                    wr_q, wr_d;

   // Next-state logic; the NIC strobe for the state being entered is decided
   // here so that it is registered and visible during that state's cycle.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = done_q;
      tx_d      = tx_q;
      rx_cnt_d  = rx_cnt_q;
      rx_last_d = rx_last_q;
      gap_cnt_d = (gap_cnt_q != 8'd0) ? gap_cnt_q - 8'd1 : 8'd0;
      gap_r_d   = gap_r_q;
      hdr_r_d   = hdr_r_q;
      addr_d    = addr_q;
      d_in_d    = d_in_q;
      en_d      = 1'b0;
      wr_d      = 1'b0;

      case (state_q)
         IDLE: state_d = TXQ;
         TXQ:  state_d = (busy_q && gap_cnt_q == 8'd0) ? TXS : RXQ;
         TXS:  state_d = (d_out[0] == 1'b0) ? TXW : RXQ;
         TXW: begin
            tx_d      = tx_q + 16'd1;
            gap_cnt_d = gap_r_q;
            if (tx_q + 16'd1 == NUM_PKTS_W) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
            state_d = RXQ;
         end
         RXQ:  state_d = RXS;
         RXS:  state_d = d_out[0] ? RXR : TXQ;
         RXR:  state_d = RXD;
         RXD: begin
            rx_last_d = d_out;
            rx_cnt_d  = rx_cnt_q + 16'd1;
            state_d   = TXQ;
         end
         default: state_d = IDLE;
      endcase

      // A start while a run is in progress is dropped on purpose.
      if (start && !busy_q) begin
         tx_d      = 16'd0;
         gap_cnt_d = 8'd0;
         hdr_r_d   = hdr;
         gap_r_d   = gap;
         busy_d    = (NUM_PKTS_W != 16'd0);
         done_d    = (NUM_PKTS_W == 16'd0);
      end

      case (state_d)
         TXQ: begin
            if (busy_d && gap_cnt_d == 8'd0) begin
               en_d   = 1'b1;
               addr_d = A_OUT_STAT;
            end
         end
         TXW: begin
            en_d   = 1'b1;
            wr_d   = 1'b1;
            addr_d = A_OUT_DATA;
            d_in_d = PACKET_WIDTH'({hdr_r_d, 16'h0000, tx_d});
         end
         RXQ: begin
            en_d   = 1'b1;
            addr_d = A_IN_STAT;
         end
         RXR: begin
            en_d   = 1'b1;
            addr_d = A_IN_DATA;
         end
         default: en_d = 1'b0;
      endcase
   end

   // All state and registered outputs; reset abandons any NIC access in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tx_q      <= 16'd0;
         rx_cnt_q  <= 16'd0;
         rx_last_q <= '0;
         gap_cnt_q <= 8'd0;
         gap_r_q   <= 8'd0;
         hdr_r_q   <= 32'd0;
         addr_q    <= 2'b00;
         d_in_q    <= '0;
         en_q      <= 1'b0;
         wr_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         tx_q      <= tx_d;
         rx_cnt_q  <= rx_cnt_d;
         rx_last_q <= rx_last_d;
         gap_cnt_q <= gap_cnt_d;
         gap_r_q   <= gap_r_d;
         hdr_r_q   <= hdr_r_d;
         addr_q    <= addr_d;
         d_in_q    <= d_in_d;
         en_q      <= en_d;
         wr_q      <= wr_d;
      end
   end

   assign addr     = addr_q;
   assign d_in     = d_in_q;
   assign nicEn    = en_q;
   assign nicEnWR  = wr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign tx_count = tx_q;
   assign rx_count = rx_cnt_q;
   assign rx_last  = rx_last_q;

endmodule

// File: tb/tb_pe_traffic_gen.sv
// tb/tb_pe_traffic_gen.sv - directed self-checking bench for pe_traffic_gen
module tb_pe_traffic_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] hdr = 32'd0;
   logic [7:0]  gap = 8'd0;
   logic [1:0]  addr;
   logic [63:0] d_in;
   logic [63:0] d_out;
   logic        nicEn;
   logic        nicEnWR;
   logic        busy;
   logic        done;
   logic [15:0] tx_count;
   logic [15:0] rx_count;
   logic [63:0] rx_last;

   int checks = 0;
   int failures = 0;

   logic        out_full = 1'b0;
   logic [63:0] in_data = 64'd0;
   int          in_push = 0;
   int          in_pop = 0;
   int          cyc = 0;
   int          rd00 = 0;
   int          rd01 = 0;
   int          rd11 = 0;
   int          bad_acc = 0;
   logic [63:0] wr_data[$];
   int          wr_cyc[$];

   pe_traffic_gen #(.PACKET_WIDTH(64), .NUM_PKTS(4)) dut (
      .clk(clk), .reset(reset), .start(start), .hdr(hdr), .gap(gap),
      .addr(addr), .d_in(d_in), .d_out(d_out), .nicEn(nicEn), .nicEnWR(nicEnWR),
      .busy(busy), .done(done), .tx_count(tx_count), .rx_count(rx_count), .rx_last(rx_last)
   );

   always #5 clk = ~clk;

   // NIC model: read data returned the cycle after the strobe, writes logged
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         d_out <= 64'd0;
      end else if (nicEn && !nicEnWR) begin
         case (addr)
            2'b00: begin
               d_out <= in_data;
               rd00  <= rd00 + 1;
               if (in_push != in_pop) in_pop <= in_pop + 1;
            end
            2'b01: begin
               d_out <= {63'd0, in_push != in_pop};
               rd01  <= rd01 + 1;
            end
            2'b11: begin
               d_out <= {63'd0, out_full};
               rd11  <= rd11 + 1;
            end
            default: bad_acc <= bad_acc + 1;
         endcase
      end else if (nicEn && nicEnWR) begin
         if (addr == 2'b10) begin
            wr_data.push_back(d_in);
            wr_cyc.push_back(cyc);
         end else begin
            bad_acc <= bad_acc + 1;
         end
      end
   end

   task automatic pulse_start(input logic [31:0] h, input logic [7:0] g);
      @(negedge clk);
      hdr = h;
      gap = g;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (wr_data.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      int r01, r00, r11, nw, nb;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (nicEn !== 1'b0) begin failures++; $display("FAIL reset_nicEn got=%0h exp=0", nicEn); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", done); end
      checks++; if (tx_count !== 16'd0) begin failures++; $display("FAIL reset_tx got=%0h exp=0", tx_count); end
      checks++; if (rx_last !== 64'd0) begin failures++; $display("FAIL reset_rx_last got=%0h exp=0", rx_last); end
      checks++; if (d_in !== 64'd0 || addr !== 2'b00) begin failures++; $display("FAIL reset_bus got d_in=%0h addr=%0h exp=0", d_in, addr); end
      r01 = rd01; r00 = rd00; r11 = rd11; nw = wr_data.size(); nb = bad_acc;
      reset = 1'b0;
      repeat (30) @(negedge clk);
      checks++; if (rd01 - r01 < 9 || rd01 - r01 > 11) begin failures++; $display("FAIL idle_rd01 got=%0d exp=9..11", rd01 - r01); end
      checks++; if (rd00 != r00 || rd11 != r11 || bad_acc != nb) begin failures++; $display("FAIL idle_other_access got rd00=%0d rd11=%0d bad=%0d exp=0", rd00 - r00, rd11 - r11, bad_acc - nb); end
      checks++; if (wr_data.size() != nw) begin failures++; $display("FAIL idle_writes got=%0d exp=0", wr_data.size() - nw); end
      checks++; if (tx_count !== 16'd0 || rx_count !== 16'd0 || done !== 1'b0) begin failures++; $display("FAIL idle_counters got tx=%0d rx=%0d done=%0h exp=0", tx_count, rx_count, done); end
   endtask

   task automatic test_basic;
      int b;
      bit ok;
      logic [63:0] exp;
      b = wr_data.size();
      pulse_start(32'hA5A5_0001, 8'd0);
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL basic_busy got busy=%0h done=%0h exp busy=1 done=0", busy, done); end
      wait_done(200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got done=%0h exp=1", done); end
      checks++; if (wr_data.size() != b + 4) begin failures++; $display("FAIL basic_nwrites got=%0d exp=4", wr_data.size() - b); end
      checks++; if (busy !== 1'b0 || tx_count !== 16'd4) begin failures++; $display("FAIL basic_end got busy=%0h tx=%0d exp busy=0 tx=4", busy, tx_count); end
      for (int i = 0; i < 4 && b + i < wr_data.size(); i++) begin
         exp = {32'hA5A5_0001, 16'h0000, 16'(i)};
         checks++; if (wr_data[b+i] !== exp) begin failures++; $display("FAIL basic_data%0d got=%h exp=%h", i, wr_data[b+i], exp); end
         if (i > 0) begin
            checks++; if (wr_cyc[b+i] - wr_cyc[b+i-1] != 5) begin failures++; $display("FAIL basic_spacing%0d got=%0d exp=5", i, wr_cyc[b+i] - wr_cyc[b+i-1]); end
         end
      end
   endtask

   task automatic test_stall;
      int b, w;
      bit ok;
      logic [63:0] exp;
      b = wr_data.size();
      pulse_start(32'hA5A5_0002, 8'd0);
      wait_writes(b + 2, 100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stall_pre_timeout got=%0d exp=2", wr_data.size() - b); end
      out_full = 1'b1;
      w = wr_data.size();
      repeat (20) @(negedge clk);
      checks++; if (wr_data.size() != w) begin failures++; $display("FAIL stall_writes got=%0d exp=0", wr_data.size() - w); end
      checks++; if (tx_count !== 16'd2 || busy !== 1'b1) begin failures++; $display("FAIL stall_hold got tx=%0d busy=%0h exp tx=2 busy=1", tx_count, busy); end
      out_full = 1'b0;
      wait_done(200, ok);
      checks++; if (!ok || wr_data.size() != b + 4) begin failures++; $display("FAIL stall_resume got done=%0h n=%0d exp done=1 n=4", done, wr_data.size() - b); end
      for (int i = 0; i < 4 && b + i < wr_data.size(); i++) begin
         exp = {32'hA5A5_0002, 16'h0000, 16'(i)};
         checks++; if (wr_data[b+i] !== exp) begin failures++; $display("FAIL stall_data%0d got=%h exp=%h", i, wr_data[b+i], exp); end
      end
   endtask

   task automatic test_rx;
      logic [15:0] r0;
      int d0;
      bit ok;
      r0 = rx_count;
      d0 = rd00;
      in_data = 64'hDEAD_BEEF_0000_0007;
      in_push = in_push + 1;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (rd00 > d0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++; if (!ok) begin failures++; $display("FAIL rx_read_timeout got rd00=%0d exp=1", rd00 - d0); end
      checks++; if (rx_count !== r0) begin failures++; $display("FAIL rx_early got=%0d exp=%0d", rx_count, r0); end
      @(negedge clk);
      checks++; if (rx_count !== r0 + 16'd1) begin failures++; $display("FAIL rx_count got=%0d exp=%0d", rx_count, r0 + 16'd1); end
      checks++; if (rx_last !== 64'hDEAD_BEEF_0000_0007) begin failures++; $display("FAIL rx_last got=%h exp=deadbeef00000007", rx_last); end
      repeat (20) @(negedge clk);
      checks++; if (rd00 != d0 + 1 || rx_count !== r0 + 16'd1) begin failures++; $display("FAIL rx_once got rd00=%0d rx=%0d exp rd00=1 rx=%0d", rd00 - d0, rx_count, r0 + 16'd1); end
   endtask

   task automatic test_gap;
      int b;
      bit ok;
      logic [15:0] t;
      b = wr_data.size();
      pulse_start(32'hC0DE_0003, 8'd10);
      wait_writes(b + 2, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL gap_pre_timeout got=%0d exp=2", wr_data.size() - b); end
      t = tx_count;
      pulse_start(32'hFFFF_FFFF, 8'd0);
      checks++; if (tx_count !== t || busy !== 1'b1) begin failures++; $display("FAIL gap_restart got tx=%0d busy=%0h exp tx=%0d busy=1", tx_count, busy, t); end
      wait_done(300, ok);
      checks++; if (!ok || wr_data.size() != b + 4) begin failures++; $display("FAIL gap_done got done=%0h n=%0d exp done=1 n=4", done, wr_data.size() - b); end
      for (int i = 0; i < 4 && b + i < wr_data.size(); i++) begin
         checks++; if (wr_data[b+i] !== {32'hC0DE_0003, 16'h0000, 16'(i)}) begin failures++; $display("FAIL gap_data%0d got=%h exp=c0de0003_0000_%04h", i, wr_data[b+i], i); end
         if (i > 0) begin
            checks++; if (wr_cyc[b+i] - wr_cyc[b+i-1] < 11) begin failures++; $display("FAIL gap_spacing%0d got=%0d exp>=11", i, wr_cyc[b+i] - wr_cyc[b+i-1]); end
         end
      end
   endtask

   task automatic test_reset_mid;
      int b, b2;
      bit ok;
      b = wr_data.size();
      pulse_start(32'h1111_2222, 8'd0);
      wait_writes(b + 2, 100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rmid_pre_timeout got=%0d exp=2", wr_data.size() - b); end
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || tx_count !== 16'd0) begin failures++; $display("FAIL rmid_ctrl got busy=%0h done=%0h tx=%0d exp 0", busy, done, tx_count); end
      checks++; if (rx_count !== 16'd0 || rx_last !== 64'd0) begin failures++; $display("FAIL rmid_rx got rx=%0d last=%h exp 0", rx_count, rx_last); end
      checks++; if (nicEn !== 1'b0 || nicEnWR !== 1'b0 || addr !== 2'b00 || d_in !== 64'd0) begin failures++; $display("FAIL rmid_bus got en=%0h wr=%0h addr=%0h d_in=%h exp 0", nicEn, nicEnWR, addr, d_in); end
      b2 = wr_data.size();
      checks++; if (b2 != b + 2) begin failures++; $display("FAIL rmid_count got=%0d exp=2", b2 - b); end
      pulse_start(32'h3333_4444, 8'd0);
      wait_done(200, ok);
      checks++; if (!ok || wr_data.size() != b2 + 4) begin failures++; $display("FAIL rmid_rerun got done=%0h n=%0d exp done=1 n=4", done, wr_data.size() - b2); end
      if (wr_data.size() >= b2 + 4) begin
         checks++; if (wr_data[b2] !== 64'h3333_4444_0000_0000) begin failures++; $display("FAIL rmid_first got=%h exp=3333444400000000", wr_data[b2]); end
         checks++; if (wr_data[b2+3] !== 64'h3333_4444_0000_0003) begin failures++; $display("FAIL rmid_last got=%h exp=3333444400000003", wr_data[b2+3]); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_stall;
      test_rx;
      test_gap;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
